prio_deco: RTL and testbench

PRIO_DECO -- requirements
Module: prio_deco

---
 rtl/prio_deco.sv | 115 +++++++++++
 tb/tb_prio_deco.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/prio_deco.sv
// Registered one-hot decoder for a priority-encoder index, with a valid/ready
// output stage and a flushable accumulated mask with population count.
//
// state | meaning
// EMPTY | no undelivered decode, out_valid=0, out_onehot=0
// FULL  | out_onehot holds a decode not yet taken by downstream
module prio_deco #(
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [2**IDX_W-1:0]  out_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**IDX_W-1:0]  out_mask,
  output logic [IDX_W:0]       out_count,
  output logic                 out_dup
);

  localparam int OUT_W = 2**IDX_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_onehot;
  logic [OUT_W-1:0] w_onehot_nxt;
  logic [OUT_W-1:0] r_mask;
  logic [OUT_W-1:0] w_mask_nxt;
  logic [IDX_W:0]   r_count;
  logic [IDX_W:0]   w_count_nxt;
  logic             r_dup;
  logic             w_dup_nxt;
  logic             w_accept;
  logic [OUT_W-1:0] w_dec;

  assign in_ready = (r_state == EMPTY) || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_dec    = OUT_W'(1) << in_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_onehot_nxt = r_onehot;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = FULL;
          w_onehot_nxt = w_dec;
        end
      end
      FULL: begin
        if (w_accept) begin
          w_state_nxt  = FULL;
          w_onehot_nxt = w_dec;
        end else if (out_ready) begin
          w_state_nxt  = EMPTY;
          w_onehot_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = EMPTY;
        w_onehot_nxt = '0;
      end
    endcase
  end

  // Flush clears the old mask before the new bit is ORed in.
  always_comb begin
    w_mask_nxt = flush ? '0 : r_mask;
    if (w_accept) begin
      w_mask_nxt = w_mask_nxt | w_dec;
    end
    w_dup_nxt = w_accept && !flush && ((r_mask & w_dec) != '0);
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_count_nxt = w_count_nxt + {{IDX_W{1'b0}}, w_mask_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot <= '0;
      r_mask   <= '0;
      r_count  <= '0;
      r_dup    <= 1'b0;
    end else begin
      r_onehot <= w_onehot_nxt;
      r_mask   <= w_mask_nxt;
      r_count  <= w_count_nxt;
      r_dup    <= w_dup_nxt;
    end
  end

  assign out_valid  = (r_state == FULL);
  assign out_onehot = r_onehot;
  assign out_mask   = r_mask;
  assign out_count  = r_count;
  assign out_dup    = r_dup;

endmodule

// File: tb/tb_prio_deco.sv
// Directed scenarios plus random traffic against a set-based reference model.
module tb_prio_deco;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_idx = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       out_dup;

  int total = 0;
  int bad   = 0;

  // reference model: a set of seen indices plus the pending output slot
  bit  seen [8];
  bit  m_valid;
  int  m_idx;
  bit  m_dup;
  bit  dup_seen;

  prio_deco #(.IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_onehot(out_onehot),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_count(out_count), .out_dup(out_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_mask();
    int s = 0;
    for (int i = 0; i < 8; i++) if (seen[i]) s += (1 << i);
    return s;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) if (seen[i]) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_dup   = 1'b0;
  endtask

  task automatic chk_outputs();
    chk("out_valid",  out_valid,  m_valid);
    chk("out_onehot", out_onehot, m_valid ? (1 << m_idx) : 0);
    chk("out_mask",   out_mask,   m_mask());
    chk("out_count",  out_count,  m_count());
    chk("out_dup",    out_dup,    m_dup);
    if (out_dup) dup_seen = 1'b1;
  endtask

  // Called at a negedge; drives inputs, runs one rising edge, checks at next negedge.
  task automatic cycle(input bit v, input bit [2:0] idx, input bit rdy, input bit fl);
    bit rdy_exp, acc;
    in_valid  = v;
    in_idx    = idx;
    out_ready = rdy;
    flush     = fl;
    #1;
    rdy_exp = !m_valid || rdy;
    chk("in_ready", in_ready, rdy_exp);
    acc = v && rdy_exp;
    @(posedge clk);
    m_dup = acc && !fl && seen[idx];
    if (fl) for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    if (acc) begin
      seen[idx] = 1'b1;
      m_valid   = 1'b1;
      m_idx     = idx;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk_outputs();
  endtask

  initial begin
    m_reset();
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // sweep 0..7
    dup_seen = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1, 3'(i), 1, 0);
    chk("sweep_mask", out_mask, 8'hFF);
    chk("sweep_count", out_count, 8);
    chk("sweep_nodup", dup_seen, 0);
    cycle(0, 0, 1, 1);

    // backpressure
    cycle(1, 5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2, 0, 0);
      chk("bp_hold", out_onehot, 8'h20);
    end
    cycle(1, 2, 1, 0);
    chk("bp_release", out_onehot, 8'h04);

    // duplicate
    cycle(0, 0, 1, 1);
    cycle(1, 3, 1, 0);
    cycle(1, 3, 1, 0);
    chk("dup_pulse", out_dup, 1);
    chk("dup_mask", out_mask, 8'h08);
    cycle(0, 0, 1, 0);
    chk("dup_gone", out_dup, 0);

    // flush with and without accept
    cycle(0, 0, 1, 1);
    cycle(1, 0, 1, 0);
    cycle(1, 7, 1, 0);
    chk("fl_pre", out_mask, 8'h81);
    cycle(1, 6, 1, 1);
    chk("fl_acc_mask", out_mask, 8'h40);
    chk("fl_acc_dup", out_dup, 0);
    cycle(1, 6, 1, 1);
    chk("fl_acc_redup", out_dup, 0);
    cycle(0, 0, 1, 1);
    chk("fl_only_mask", out_mask, 0);
    chk("fl_only_count", out_count, 0);

    // async reset mid-transaction
    for (int i = 0; i < 4; i++) cycle(1, 3'(i), 1, 0);
    cycle(0, 0, 0, 0);
    chk("ar_pre_mask", out_mask, 8'h0F);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("ar_in_ready", in_ready, 1);
    chk_outputs();
    in_valid = 1'b1;
    in_idx   = 3'd4;
    @(posedge clk);
    @(negedge clk);
    chk_outputs();
    rst_n = 1'b1;
    cycle(1, 7, 0, 0);
    chk("ar_onehot", out_onehot, 8'h80);
    chk("ar_mask", out_mask, 8'h80);

    // idle with toggling index, draining the output
    for (int i = 0; i < 10; i++) cycle(0, 3'($urandom_range(0, 7)), 1, 0);
    chk("idle_mask", out_mask, 8'h80);
    chk("idle_valid", out_valid, 0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
